// File: rtl/multicycle_cla_adder_pkg.sv
// Shared definitions for the nibble-serial carry look-ahead adder.
package multicycle_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 4;

endpackage

// File: rtl/multicycle_cla_adder_if.sv
// Operand and result channels of the multicycle adder.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both 1;
// the sender holds data only for that edge, and valid never waits on ready.
interface multicycle_cla_adder_if #(parameter int WIDTH = 16) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );

endinterface

// File: rtl/multicycle_cla_adder_cla4.sv
// Combinational 4-bit carry look-ahead slice; c_msb is the carry into bit 3.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       c_msb
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    assign sum   = w_p ^ w_c[3:0];
    assign cout  = w_c[4];
    assign c_msb = w_c[3];

endmodule

// File: rtl/multicycle_cla_adder.sv
// Nibble-serial WIDTH-bit adder: one CLA slice reused for WIDTH/4 cycles, LSB nibble first,
// with the carry held in a register between cycles.
module multicycle_cla_adder
    import multicycle_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    multicycle_cla_adder_if.slave        bus,
    output state_t                       o_dbg_state
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
            $error("multicycle_cla_adder: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum_sh;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic [3:0]         w_slice_sum;
    logic               w_slice_cout;
    logic               w_slice_cmsb;
    logic               w_last;
    logic [WIDTH-1:0]   w_sum_next;

    cla4_slice u_slice (
        .a     (r_a_sh[3:0]),
        .b     (r_b_sh[3:0]),
        .cin   (r_carry),
        .sum   (w_slice_sum),
        .cout  (w_slice_cout),
        .c_msb (w_slice_cmsb)
    );

    // New nibble enters from the top so the LSB nibble lands at bit 0 after NSLICE shifts.
    assign w_sum_next = (r_sum_sh >> SLICE_W) | (WIDTH'(w_slice_sum) << (WIDTH - SLICE_W));
    assign w_last     = (r_state == CALC) && (r_cnt == LAST_CNT);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_state_nxt = CALC;
            CALC:    if (w_last)       w_state_nxt = DONE;
            DONE:    if (bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a_sh   <= bus.a;
                        r_b_sh   <= bus.b;
                        r_sum_sh <= '0;
                        r_carry  <= bus.cin;
                        r_cnt    <= '0;
                    end
                end
                CALC: begin
                    r_sum_sh <= w_sum_next;
                    r_carry  <= w_slice_cout;
                    r_a_sh   <= r_a_sh >> SLICE_W;
                    r_b_sh   <= r_b_sh >> SLICE_W;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_sum  <= w_sum_next;
                        r_cout <= w_slice_cout;
                        r_ovf  <= w_slice_cmsb ^ w_slice_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.overflow  = r_ovf;
    assign o_dbg_state   = r_state;

endmodule

// File: doc/multicycle_cla_adder.md
Name: multicycle_cla_adder

Overview:
- Sequential WIDTH-bit adder built around a single 4-bit carry look-ahead slice.
- Processes one 4-bit nibble per clock, LSB nibble first, with a registered carry chained between cycles.
- Trades latency for area in front of wide datapaths.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥4 (elaboration error otherwise).
- NSLICE (localparam), WIDTH/4, number of CALC cycles per operation.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands; equals (state==IDLE)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- out_valid  out  1  result valid; equals (state==DONE)
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  registered sum
- cout  out  1  registered carry-out of bit WIDTH-1
- overflow  out  1  registered signed overflow (carry into MSB XOR cout)

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high, sampled on rising clk.
- Reset state: state=IDLE, sum=0, cout=0, overflow=0, carry_reg=0, nibble counter=0.
  - After the reset edge: in_ready=1, out_valid=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a, b into shift registers, load cin into carry_reg, clear counter, go to CALC.
- CALC:
  - in_ready=0. in_valid and operand inputs are ignored.
  - Each edge: the cla4_slice adds a_sh[3:0] + b_sh[3:0] + carry_reg.
  - The 4-bit result shifts into sum_sh from the top (sum_sh = {slice_sum, sum_sh[WIDTH-1:4]}).
  - carry_reg updates to the slice carry-out; a_sh and b_sh shift right by 4; counter increments.
  - On the edge where counter==NSLICE-1:
    - sum <= final sum_sh value; cout <= slice cout.
    - overflow <= slice c_msb XOR slice cout.
    - Go to DONE.
- Latency: operands accepted at edge k → out_valid=1 during the cycle after edge k+NSLICE. With WIDTH=16, out_valid rises 4 cycles after acceptance.
- DONE:
  - out_valid=1; sum, cout and overflow are held stable.
  - On an edge with out_ready=1: go to IDLE. sum/cout/overflow keep their values until the next completion.
  - Backpressure is unlimited.
- Throughput: at most one operation per NSLICE+2 cycles. No overlap: in_ready=0 in DONE even if out_ready=1.
- Arithmetic: unsigned modulo 2^WIDTH; cout is bit WIDTH of a+b+cin. overflow treats a and b as two's complement.
- Reset mid-operation (CALC or DONE): operation aborted, no out_valid pulse, all outputs return to reset values on that edge.
- in_valid while in_ready=0: ignored, not queued.
- Operand inputs need only be stable at the accepting edge.

Decomposition:
- Shared package/header multicycle_adder_pkg:
  - state encoding IDLE=2'd0, CALC=2'd1, DONE=2'd2
  - SLICE_W=4
- Sub-module cla4_slice (purely combinational):
  - inputs: a[3:0], b[3:0], cin
  - outputs: sum[3:0], cout, c_msb (carry into bit 3)
  - generate/propagate look-ahead equations.
- Top holds the FSM, counter, shift registers and output registers.

Test Plan:
1. WIDTH=16, a=16'h1234, b=16'h4321, cin=0, out_ready=1 → sum=16'h5555, cout=0, overflow=0; out_valid high exactly 4 cycles after the accept edge, for one cycle.
2. a=16'hFFFF, b=16'h0000, cin=1 → sum=16'h0000, cout=1, overflow=0 (carry ripples through all 4 slices via carry_reg).
3. a=16'h7FFF, b=16'h0001, cin=0 → sum=16'h8000, cout=0, overflow=1.
4. Backpressure: op a=16'h00FF, b=16'h0001, cin=0 with out_ready=0 for 5 cycles in DONE, and in_valid=1 with a different operand during that time.
   - out_valid stays 1 and sum=16'h0100 stays stable; in_ready=0; the extra operand is not consumed.
   - After out_ready=1: IDLE, then the pending operand is accepted.
5. Reset asserted for one cycle at the 2nd CALC cycle → next cycle in_ready=1, out_valid=0, sum=0. Then a=16'hA5A5, b=16'h5A5A, cin=1 → sum=16'h0000, cout=1, overflow=0.
6. WIDTH=4 instance: a=4'hA, b=4'h5, cin=0 → sum=4'hF, cout=0; out_valid one cycle after the accept edge. Then a=4'h8, b=4'hD, cin=1 → sum=4'h6, cout=1, overflow=1.
